// File: rtl/serial_word_feeder.sv
// serial_word_feeder: assembles a serial bit stream into WIDTH-bit words and
// presents each completed word on word_o with a one-cycle ld_o strobe.
// Optional feature macro: PARITY_EN. When defined, every word is followed by
// an even-parity bit; words with bad parity are dropped and flagged on err_o.
module serial_word_feeder #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             sin_i,
  input  logic             sin_en_i,
  input  logic             restart_i,
  output logic [WIDTH-1:0] word_o,
  output logic             ld_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [WIDTH-1:0] word, word_nxt;
  logic             ld, ld_nxt;
  logic [WIDTH-1:0] shifted;

  // Next shift-register contents if the current sin_i bit is taken.
  always_comb begin
    if (MSB_FIRST) shifted = {sr[WIDTH-2:0], sin_i};
    else           shifted = {sin_i, sr[WIDTH-1:1]};
  end

`ifdef PARITY_EN
  logic err, err_nxt;
`endif

  // State register plus all output registers; clear_i wins immediately.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      word  <= '0;
      ld    <= 1'b0;
`ifdef PARITY_EN
      err   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      word  <= word_nxt;
      ld    <= ld_nxt;
`ifdef PARITY_EN
      err   <= err_nxt;
`endif
    end
  end

  // Next-state logic: restart drops any partial word (including one that
  // would complete on this edge); otherwise consume one bit per sin_en_i.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    word_nxt  = word;
    ld_nxt    = 1'b0;
`ifdef PARITY_EN
    err_nxt   = 1'b0;
`endif
    if (restart_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      sr_nxt    = '0;
    end else if (sin_en_i) begin
      unique case (state)
        IDLE, SHIFT: begin
          if (cnt == LAST) begin
`ifdef PARITY_EN
            // Data complete; hold it until the parity bit arrives.
            sr_nxt    = shifted;
            cnt_nxt   = '0;
            state_nxt = PAR;
`else
            word_nxt  = shifted;
            ld_nxt    = 1'b1;
            sr_nxt    = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
`endif
          end else begin
            sr_nxt    = shifted;
            cnt_nxt   = cnt + 1'b1;
            state_nxt = SHIFT;
          end
        end
        PAR: begin
`ifdef PARITY_EN
          // Even parity across data and parity bit must reduce to 0.
          if (^{sr, sin_i} == 1'b0) begin
            word_nxt = sr;
            ld_nxt   = 1'b1;
          end else begin
            err_nxt  = 1'b1;
          end
`endif
          sr_nxt    = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
        default: begin
          sr_nxt    = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign word_o = word;
  assign ld_o   = ld;
  assign busy_o = (cnt != '0) || (state == PAR);
`ifdef PARITY_EN
  assign err_o  = err;
`else
  assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder (WIDTH=4, MSB first). Define PARITY_EN
// for both bench and design to exercise the parity path instead.
module tb_serial_word_feeder;

  logic       clk_i = 1'b0;
  logic       clear_i;
  logic       sin_i;
  logic       sin_en_i;
  logic       restart_i;
  logic [3:0] word_o;
  logic       ld_o;
  logic       busy_o;
  logic       err_o;

  int n_chk  = 0;
  int n_pass = 0;

  serial_word_feeder #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk_i(clk_i), .clear_i(clear_i), .sin_i(sin_i), .sin_en_i(sin_en_i),
    .restart_i(restart_i), .word_o(word_o), .ld_o(ld_o), .busy_o(busy_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic b);
    sin_i    = b;
    sin_en_i = 1'b1;
    tick();
  endtask

  task automatic gap();
    sin_en_i = 1'b0;
    tick();
  endtask

  task automatic send4(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send(w[i]);
  endtask

  logic [11:0] stream;
  logic [3:0]  exp3 [3];
  int          ld_cnt;

  initial begin
    clear_i   = 1'b1;
    sin_i     = 1'b0;
    sin_en_i  = 1'b0;
    restart_i = 1'b0;

    // 1: reset
    #1;
    check("rst_word", word_o, 4'h0);
    check("rst_ld",   ld_o,   1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err",  err_o,  1'b0);
    #5 clear_i = 1'b0;
    tick();
    check("post_rst_word", word_o, 4'h0);
    check("post_rst_busy", busy_o, 1'b0);
    check("post_rst_ld",   ld_o,   1'b0);

`ifdef PARITY_EN
    // 6: good parity word, then a bad-parity word and a second bad one
    send4(4'b1011);
    check("p_wait_ld",   ld_o,   1'b0);
    check("p_wait_busy", busy_o, 1'b1);
    send(1'b1);
    check("p_good_ld",   ld_o,   1'b1);
    check("p_good_word", word_o, 4'b1011);
    check("p_good_err",  err_o,  1'b0);
    check("p_good_busy", busy_o, 1'b0);
    send4(4'b0111);
    send(1'b0);
    check("p_bad_err",  err_o,  1'b1);
    check("p_bad_ld",   ld_o,   1'b0);
    check("p_bad_word", word_o, 4'b1011);
    gap();
    check("p_err_pulse", err_o, 1'b0);
    send4(4'b0110);
    send(1'b0);
    check("p_good2_word", word_o, 4'b0110);
    send4(4'b1011);
    send(1'b0);
    check("p_bad2_err",  err_o,  1'b1);
    check("p_bad2_word", word_o, 4'b0110);
    check("p_bad2_ld",   ld_o,   1'b0);
    gap();
`else
    // 2: single word 1,0,1,1
    send(1'b1);
    check("w1_busy1", busy_o, 1'b1);
    check("w1_ld1",   ld_o,   1'b0);
    send(1'b0);
    send(1'b1);
    check("w1_busy3", busy_o, 1'b1);
    check("w1_ld3",   ld_o,   1'b0);
    send(1'b1);
    check("w1_word", word_o, 4'b1011);
    check("w1_ld",   ld_o,   1'b1);
    check("w1_busy", busy_o, 1'b0);
    gap();
    check("w1_ld_drop", ld_o,   1'b0);
    check("w1_hold",    word_o, 4'b1011);

    // 3: back-to-back words F, E, 0
    stream = 12'b1111_1110_0000;
    exp3   = '{4'hF, 4'hE, 4'h0};
    ld_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      send(stream[11-i]);
      if (ld_o) ld_cnt++;
      if (i % 4 == 3) begin
        check($sformatf("b2b_ld%0d", i), ld_o, 1'b1);
        check($sformatf("b2b_word%0d", i), word_o, exp3[i/4]);
      end else begin
        check($sformatf("b2b_noload%0d", i), ld_o, 1'b0);
      end
    end
    check("b2b_count", ld_cnt, 3);
    gap();

    // 4: gap inside a word
    send(1'b1);
    send(1'b0);
    for (int i = 0; i < 3; i++) begin
      gap();
      check("gap_ld",   ld_o,   1'b0);
      check("gap_busy", busy_o, 1'b1);
    end
    send(1'b1);
    check("gap_ld_early", ld_o, 1'b0);
    send(1'b1);
    check("gap_word", word_o, 4'b1011);
    check("gap_ld_done", ld_o, 1'b1);
    gap();

    // 5a: async clear mid-cycle with a partial word held
    send(1'b0);
    send(1'b1);
    sin_en_i = 1'b0;
    #3 clear_i = 1'b1;
    #1;
    check("aclr_word", word_o, 4'h0);
    check("aclr_busy", busy_o, 1'b0);
    check("aclr_ld",   ld_o,   1'b0);
    clear_i = 1'b0;
    tick();
    send4(4'b0101);
    check("aclr_next_word", word_o, 4'b0101);
    check("aclr_next_ld",   ld_o,   1'b1);
    gap();

    // 5b: restart on the completing edge drops the word
    send(1'b1);
    send(1'b1);
    send(1'b1);
    restart_i = 1'b1;
    send(1'b1);
    restart_i = 1'b0;
    check("rs_ld",   ld_o,   1'b0);
    check("rs_word", word_o, 4'b0101);
    check("rs_busy", busy_o, 1'b0);
    send4(4'b0011);
    check("rs_next_word", word_o, 4'b0011);
    check("rs_next_ld",   ld_o,   1'b1);
    gap();
    check("err_tied", err_o, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
